// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write arbiter.
//   RF_ADDR_W / RF_DATA_W : register index and data widths
//   wb_req_t              : one buffered writeback {addr, data}
//   wb_src_e              : which source owned a committed write
package rf_wb_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      WB_SRC_PIPE = 1'b0,
      WB_SRC_SIDE = 1'b1
   } wb_src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between the writeback sources / hazard unit and the arbiter.
//   wb0_*         : pipeline writeback (no backpressure)
//   wb1_*         : side-unit writeback (valid/ready)
//   rf_*          : register-file write port
//   stall_req     : pipeline hold request
//   query_*       : hazard-unit pending-write lookup
//   fifo_count    : buffered side-unit entries
//   trace_*       : committed-write trace (only with RF_WB_TRACE_EN)
// modport master = sources/hazard unit, modport slave = arbiter.
interface rf_write_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 2
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                  wb0_valid;
   logic [ADDR_WIDTH-1:0] wb0_addr;
   logic [DATA_WIDTH-1:0] wb0_data;
   logic                  wb1_valid;
   logic                  wb1_ready;
   logic [ADDR_WIDTH-1:0] wb1_addr;
   logic [DATA_WIDTH-1:0] wb1_data;
   logic                  rf_wen;
   logic [ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0] rf_wdata;
   logic                  stall_req;
   logic [ADDR_WIDTH-1:0] query_addr;
   logic                  query_pending;
   logic [CNT_W-1:0]      fifo_count;
`ifdef RF_WB_TRACE_EN
   logic                  trace_valid;
   logic                  trace_src;
   logic [ADDR_WIDTH-1:0] trace_addr;
   logic [DATA_WIDTH-1:0] trace_data;

   modport master (
      output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, query_addr,
      input  wb1_ready, rf_wen, rf_waddr, rf_wdata, stall_req, query_pending, fifo_count,
             trace_valid, trace_src, trace_addr, trace_data
   );
   modport slave (
      input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, query_addr,
      output wb1_ready, rf_wen, rf_waddr, rf_wdata, stall_req, query_pending, fifo_count,
             trace_valid, trace_src, trace_addr, trace_data
   );
`else
   modport master (
      output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, query_addr,
      input  wb1_ready, rf_wen, rf_waddr, rf_wdata, stall_req, query_pending, fifo_count
   );
   modport slave (
      input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data, query_addr,
      output wb1_ready, rf_wen, rf_waddr, rf_wdata, stall_req, query_pending, fifo_count
   );
`endif
endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of side-unit writebacks.
//   clock, reset : clock and synchronous active-high reset (empties the FIFO)
//   push, push_data : enqueue (caller guarantees not full)
//   pop, head    : dequeue / current head entry (caller guarantees not empty)
//   count        : occupied entries
//   ent_valid    : per-slot occupancy, ent_addr : per-slot address (flattened)
module rf_wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  wb_req_t                    push_data,
   input  logic                       pop,
   output wb_req_t                    head,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DEPTH-1:0]           ent_valid,
   output logic [DEPTH*RF_ADDR_W-1:0] ent_addr
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_req_t           mem_q [DEPTH];
   wb_req_t           mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PTR_W-1:0] offs;
      offs      = '0;
      ent_valid = '0;
      ent_addr  = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         offs         = PTR_W'(i) - rd_ptr_q;
         ent_valid[i] = ({1'b0, offs} < count_q);
         ent_addr[i*RF_ADDR_W +: RF_ADDR_W] = mem_q[i].addr;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between the pipeline WB stage
// (fixed priority) and a FIFO-buffered side unit; raises stall_req when the
// side unit is starved and answers pending-write queries for hazard checks.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : wb0/wb1 requests, rf write port, stall_req, query, fifo_count
// Optional: define RF_WB_TRACE_EN to add registered trace_* outputs.
module rf_write_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = RF_ADDR_W,
   parameter int unsigned DATA_WIDTH   = RF_DATA_W,
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   rf_write_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   wb_req_t                      push_req;
   wb_req_t                      head;
   logic                         push, pop;
   logic                         wb0_win;
   logic                         wb1_ready_c;
   logic                         fifo_empty;
   logic [CNT_W-1:0]             count;
   logic [FIFO_DEPTH-1:0]        ent_valid;
   logic [FIFO_DEPTH*RF_ADDR_W-1:0] ent_addr;
   logic [STV_W-1:0]             starve_q, starve_d;
   logic                         stall_q, stall_d;

   rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_req),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr)
   );

   assign fifo_empty = (count == '0);

   // Accept side-unit requests; x0 writes are acknowledged but never buffered.
   always_comb begin
      wb1_ready_c   = !reset && (count < CNT_W'(FIFO_DEPTH));
      push          = wb1_ready_c && bus.wb1_valid && (bus.wb1_addr != '0);
      push_req.addr = RF_ADDR_W'(bus.wb1_addr);
      push_req.data = RF_DATA_W'(bus.wb1_data);
   end

   // Write-port grant: pipeline wins, else drain the FIFO head.
   always_comb begin
      wb0_win      = !reset && bus.wb0_valid && (bus.wb0_addr != '0);
      pop          = 1'b0;
      bus.rf_wen   = 1'b0;
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
      if (wb0_win) begin
         bus.rf_wen   = 1'b1;
         bus.rf_waddr = bus.wb0_addr;
         bus.rf_wdata = bus.wb0_data;
      end else if (!reset && !fifo_empty) begin
         pop          = 1'b1;
         bus.rf_wen   = 1'b1;
         bus.rf_waddr = ADDR_WIDTH'(head.addr);
         bus.rf_wdata = DATA_WIDTH'(head.data);
      end
   end

   // Starvation counter; stall_req follows the counter hitting the limit.
   always_comb begin
      starve_d = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (starve_q < STV_W'(STARVE_LIMIT)) begin
         starve_d = starve_q + STV_W'(1);
      end
      stall_d = (starve_d == STV_W'(STARVE_LIMIT));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   // Pending-write lookup over live FIFO slots; x0 never matches.
   always_comb begin
      bus.query_pending = 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         if (ent_valid[i] &&
             (ent_addr[i*RF_ADDR_W +: RF_ADDR_W] == RF_ADDR_W'(bus.query_addr))) begin
            bus.query_pending = 1'b1;
         end
      end
      if (reset || (bus.query_addr == '0)) begin
         bus.query_pending = 1'b0;
      end
   end

   assign bus.wb1_ready  = wb1_ready_c;
   assign bus.stall_req  = stall_q;
   assign bus.fifo_count = reset ? '0 : count;

`ifdef RF_WB_TRACE_EN
   logic                  trace_valid_q, trace_valid_d;
   wb_src_e               trace_src_q, trace_src_d;
   logic [ADDR_WIDTH-1:0] trace_addr_q, trace_addr_d;
   logic [DATA_WIDTH-1:0] trace_data_q, trace_data_d;

   // Registered copy of each committed write.
   always_comb begin
      trace_valid_d = bus.rf_wen;
      trace_src_d   = pop ? WB_SRC_SIDE : WB_SRC_PIPE;
      trace_addr_d  = bus.rf_waddr;
      trace_data_d  = bus.rf_wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         trace_valid_q <= 1'b0;
         trace_src_q   <= WB_SRC_PIPE;
         trace_addr_q  <= '0;
         trace_data_q  <= '0;
      end else begin
         trace_valid_q <= trace_valid_d;
         trace_src_q   <= trace_src_d;
         trace_addr_q  <= trace_addr_d;
         trace_data_q  <= trace_data_d;
      end
   end

   assign bus.trace_valid = trace_valid_q;
   assign bus.trace_src   = trace_src_q;
   assign bus.trace_addr  = trace_addr_q;
   assign bus.trace_data  = trace_data_q;
`endif

   // Pipeline must keep WB idle while a stall is requested.
   a_no_wb0_during_stall : assert property (
      @(posedge clock) disable iff (reset) !(stall_q && bus.wb0_valid))
      else $error("wb0_valid asserted while stall_req=1");

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
   import rf_wb_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   rf_write_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) bus ();

   rf_write_arbiter #(
      .ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endfunction

   function automatic void expect_wr(logic [4:0] a, logic [31:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      bus.wb0_valid = v0;
      bus.wb0_addr  = a0;
      bus.wb0_data  = d0;
      bus.wb1_valid = v1;
      bus.wb1_addr  = a1;
      bus.wb1_data  = d1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Scoreboard monitor: every RF write must match the next expected write.
   always @(negedge clock) begin
      if (bus.rf_wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rf_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rf_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, {27'd0, e.a, e.d});
         end
      end
   end

   initial begin
      reset          = 1'b1;
      bus.query_addr = '0;
      idle();

      // Reset state
      step(); settle();
      check("rst_rf_wen",    64'(bus.rf_wen),     64'd0);
      check("rst_wb1_ready", 64'(bus.wb1_ready),  64'd0);
      check("rst_count",     64'(bus.fifo_count), 64'd0);
      check("rst_stall",     64'(bus.stall_req),  64'd0);
      step(); reset = 1'b0; settle();
      check("post_rst_ready", 64'(bus.wb1_ready),  64'd1);
      check("post_rst_count", 64'(bus.fifo_count), 64'd0);

      // Side-only write
      step(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11); expect_wr(5'd5, 32'h11); settle();
      check("side_ready",   64'(bus.wb1_ready), 64'd1);
      check("side_no_wr_c1", 64'(bus.rf_wen),   64'd0);
      step(); idle(); bus.query_addr = 5'd5; settle();
      check("side_count1",  64'(bus.fifo_count),    64'd1);
      check("side_wen_c2",  64'(bus.rf_wen),        64'd1);
      check("side_waddr",   64'(bus.rf_waddr),      64'd5);
      check("side_pending", 64'(bus.query_pending), 64'd1);
      step(); settle();
      check("side_count0",   64'(bus.fifo_count),    64'd0);
      check("side_pend_clr", 64'(bus.query_pending), 64'd0);

      // Conflict: wb0 wins, side write drains on the next idle cycle
      step(); drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB); bus.query_addr = 5'd7;
      expect_wr(5'd3, 32'hA); settle();
      check("cf_waddr_wb0", 64'(bus.rf_waddr),      64'd3);
      check("cf_pend_pre",  64'(bus.query_pending), 64'd0);
      step(); drive(1'b1, 5'd4, 32'hC, 1'b0, 5'd0, 32'd0); expect_wr(5'd4, 32'hC); settle();
      check("cf_pend_buf",  64'(bus.query_pending), 64'd1);
      check("cf_count1",    64'(bus.fifo_count),    64'd1);
      step(); idle(); expect_wr(5'd7, 32'hB); settle();
      check("cf_waddr_side", 64'(bus.rf_waddr),      64'd7);
      check("cf_pend_pop",   64'(bus.query_pending), 64'd1);
      step(); settle();
      check("cf_pend_clr", 64'(bus.query_pending), 64'd0);
      check("cf_count0",   64'(bus.fifo_count),    64'd0);
      bus.query_addr = '0;

      // Full FIFO with wb0 busy
      step(); drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'h100); expect_wr(5'd1, 32'h1); settle();
      check("full_ready_a", 64'(bus.wb1_ready), 64'd1);
      step(); drive(1'b1, 5'd1, 32'h2, 1'b1, 5'd11, 32'h101); expect_wr(5'd1, 32'h2); settle();
      check("full_ready_b", 64'(bus.wb1_ready),  64'd1);
      check("full_count_b", 64'(bus.fifo_count), 64'd1);
      step(); drive(1'b1, 5'd1, 32'h3, 1'b1, 5'd12, 32'h102); expect_wr(5'd1, 32'h3); settle();
      check("full_ready_c", 64'(bus.wb1_ready),  64'd0);
      check("full_count_c", 64'(bus.fifo_count), 64'd2);
      step(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h102); expect_wr(5'd10, 32'h100); settle();
      check("full_ready_d", 64'(bus.wb1_ready), 64'd0);
      check("full_waddr_d", 64'(bus.rf_waddr),  64'd10);
      step(); expect_wr(5'd11, 32'h101); settle();
      check("full_ready_e", 64'(bus.wb1_ready),  64'd1);
      check("full_count_e", 64'(bus.fifo_count), 64'd1);
      step(); idle(); expect_wr(5'd12, 32'h102); settle();
      check("full_count_f", 64'(bus.fifo_count), 64'd1);
      check("full_waddr_f", 64'(bus.rf_waddr),   64'd12);
      step(); settle();
      check("full_count_g", 64'(bus.fifo_count), 64'd0);
      check("full_wen_g",   64'(bus.rf_wen),     64'd0);

      // Starvation: stall after 4 unserved cycles, cleared after the pop
      step(); drive(1'b1, 5'd2, 32'h20, 1'b1, 5'd9, 32'h99); expect_wr(5'd2, 32'h20); settle();
      for (int i = 1; i <= 4; i++) begin
         step(); drive(1'b1, 5'd2, 32'h20 + 32'(i), 1'b0, 5'd0, 32'd0);
         expect_wr(5'd2, 32'h20 + 32'(i)); settle();
         check("stv_no_stall", 64'(bus.stall_req), 64'd0);
      end
      step(); idle(); expect_wr(5'd9, 32'h99); settle();
      check("stv_stall",  64'(bus.stall_req), 64'd1);
      check("stv_waddr9", 64'(bus.rf_waddr),  64'd9);
      step(); settle();
      check("stv_stall_clr", 64'(bus.stall_req),  64'd0);
      check("stv_count0",    64'(bus.fifo_count), 64'd0);

      // x0 handling
      step(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF); settle();
      check("x0_ready", 64'(bus.wb1_ready), 64'd1);
      step(); drive(1'b1, 5'd8, 32'h80, 1'b1, 5'd6, 32'h66); expect_wr(5'd8, 32'h80); settle();
      check("x0_dropped", 64'(bus.fifo_count), 64'd0);
      step(); drive(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0); expect_wr(5'd6, 32'h66); settle();
      check("x0_wb0_waddr", 64'(bus.rf_waddr), 64'd6);
      check("x0_wb0_wdata", 64'(bus.rf_wdata), 64'h66);
      step(); idle(); settle();
      check("x0_count0", 64'(bus.fifo_count), 64'd0);

      // Reset mid-operation discards buffered entries
      step(); drive(1'b1, 5'd1, 32'h31, 1'b1, 5'd13, 32'hD); expect_wr(5'd1, 32'h31); settle();
      step(); drive(1'b1, 5'd1, 32'h32, 1'b1, 5'd14, 32'hE); expect_wr(5'd1, 32'h32); settle();
      step(); idle(); reset = 1'b1; bus.query_addr = 5'd13; settle();
      check("mr_wen",   64'(bus.rf_wen),        64'd0);
      check("mr_count", 64'(bus.fifo_count),    64'd0);
      check("mr_ready", 64'(bus.wb1_ready),     64'd0);
      check("mr_pend",  64'(bus.query_pending), 64'd0);
      step(); reset = 1'b0; settle();
      check("mr_count_after", 64'(bus.fifo_count), 64'd0);
      check("mr_wen_after",   64'(bus.rf_wen),     64'd0);
      check("mr_stall_after", 64'(bus.stall_req),  64'd0);
      check("mr_pend_after",  64'(bus.query_pending), 64'd0);
      step(); settle();
      check("mr_wen_late", 64'(bus.rf_wen), 64'd0);

      step(); step(); settle();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
